// File: rtl/c17_locked_reg.sv
`timescale 1ns/1ps
// Logic-locked ISCAS-85 c17 core (key 111 unlocks) between input and output register stages.
// Latency 2 edges (1 when REGISTER_INPUTS=0); no backpressure, one vector accepted every cycle.
module c17_locked_reg #(
    parameter int unsigned REGISTER_INPUTS = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic N1,
    input  logic N2,
    input  logic N3,
    input  logic N6,
    input  logic N7,
    input  logic keyinput24,
    input  logic keyinput25,
    input  logic keyinput26,
    output logic N22,
    output logic N23
);

    logic [7:0] in_raw;
    logic [7:0] stg;

    assign in_raw = {N1, N2, N3, N6, N7, keyinput24, keyinput25, keyinput26};

    generate
        if (REGISTER_INPUTS != 0) begin : g_in_reg
            logic [7:0] in_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    in_q <= 8'd0;
                end else begin
                    in_q <= in_raw;
                end
            end
            assign stg = in_q;
        end else begin : g_in_comb
            assign stg = in_raw;
        end
    endgenerate

    logic s_n1, s_n2, s_n3, s_n6, s_n7, s_k24, s_k25, s_k26;
    logic n10, n11, k11, n16, k16, n19, k19;
    logic [1:0] out_d;
    logic [1:0] out_q;

    assign {s_n1, s_n2, s_n3, s_n6, s_n7, s_k24, s_k25, s_k26} = stg;

    // A key bit of 1 passes its net through; 0 inverts it.
    assign n10 = ~(s_n1 & s_n3);
    assign n11 = ~(s_n3 & s_n6);
    assign k11 = ~(n11 ^ s_k24);
    assign n16 = ~(s_n2 & k11);
    assign k16 = ~(n16 ^ s_k25);
    assign n19 = ~(k11 & s_n7);
    assign k19 = ~(n19 ^ s_k26);

    assign out_d = {~(n10 & k16), ~(k16 & k19)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 2'b00;
        end else begin
            out_q <= out_d;
        end
    end

    assign N22 = out_q[1];
    assign N23 = out_q[0];

endmodule

// File: tb/tb_c17_locked_reg.sv
`timescale 1ns/1ps
// Scoreboard bench for c17_locked_reg, run on a registered-input and a combinational-input build side by side.
module tb_c17_locked_reg;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic n1 = 1'b0, n2 = 1'b0, n3 = 1'b0, n6 = 1'b0, n7 = 1'b0;
    logic k24 = 1'b1, k25 = 1'b1, k26 = 1'b1;
    logic n22_r, n23_r, n22_c, n23_c;

    logic [1:0] q_reg[$];
    logic [1:0] q_cmb[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    c17_locked_reg #(.REGISTER_INPUTS(1)) u_dut_reg (
        .clk(clk), .rst_n(rst_n),
        .N1(n1), .N2(n2), .N3(n3), .N6(n6), .N7(n7),
        .keyinput24(k24), .keyinput25(k25), .keyinput26(k26),
        .N22(n22_r), .N23(n23_r)
    );

    c17_locked_reg #(.REGISTER_INPUTS(0)) u_dut_cmb (
        .clk(clk), .rst_n(rst_n),
        .N1(n1), .N2(n2), .N3(n3), .N6(n6), .N7(n7),
        .keyinput24(k24), .keyinput25(k25), .keyinput26(k26),
        .N22(n22_c), .N23(n23_c)
    );

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got N22N23=%b expected=%b at %0t", tag, got, exp, $time);
        end
    endtask

    // Original, unlocked c17 netlist; v = {N1,N2,N3,N6,N7}
    function automatic logic [1:0] c17_ref(input logic [4:0] v);
        logic a, b, c, d, e, g10, g11, g16, g19;
        {a, b, c, d, e} = v;
        g10 = ~(a & c);
        g11 = ~(c & d);
        g16 = ~(b & g11);
        g19 = ~(g11 & e);
        return {~(g10 & g16), ~(g16 & g19)};
    endfunction

    task automatic drive(input logic [4:0] v, input logic [2:0] k);
        {n1, n2, n3, n6, n7} = v;
        {k24, k25, k26} = k;
    endtask

    // Apply one vector, then compare whatever each build is due to emit after this edge.
    task automatic step(input logic [4:0] v, input logic [2:0] k, input logic [1:0] exp, input string tag);
        drive(v, k);
        q_reg.push_back(exp);
        q_cmb.push_back(exp);
        @(posedge clk);
        #1;
        check({tag, "_lat1"}, {n22_c, n23_c}, q_cmb.pop_front());
        if (q_reg.size() >= 2) check({tag, "_lat2"}, {n22_r, n23_r}, q_reg.pop_front());
    endtask

    task automatic rst_chk(input string tag);
        check({tag, "_reg"}, {n22_r, n23_r}, 2'b00);
        check({tag, "_cmb"}, {n22_c, n23_c}, 2'b00);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 rst_chk("rst_async_start");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            drive(5'($urandom), 3'($urandom));
            rst_chk("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;

        step(5'b00000, 3'b111, 2'b00, "zero_k111");
        step(5'b01001, 3'b111, 2'b11, "n2n7_k111");
        step(5'b11111, 3'b111, 2'b10, "ones_k111");
        step(5'b00110, 3'b111, 2'b00, "n3n6_k111");
        step(5'b01001, 3'b011, 2'b00, "n2n7_k24w");
        step(5'b00000, 3'b101, 2'b11, "zero_k25w");
        step(5'b00000, 3'b110, 2'b01, "zero_k26w");

        for (int i = 0; i < 32; i++) step(5'(i), 3'b111, c17_ref(5'(i)), "sweep");

        for (int i = 0; i < 16; i++) step(5'(i), 3'b111, c17_ref(5'(i)), "sweep2a");
        #2 rst_n = 1'b0;
        #1 rst_chk("rst_async_mid");
        q_reg.delete();
        q_cmb.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            drive(5'($urandom), 3'($urandom));
            rst_chk("rst_mid_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 16; i < 32; i++) step(5'(i), 3'b111, c17_ref(5'(i)), "sweep2b");
        step(5'b00000, 3'b111, 2'b00, "flush");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
